data_mem_ctrl: RTL and testbench
================================

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255: the maximum number of cycles bus_req waits for bus_ack before the access is aborted.
REQ-002 Port clk, input, width 1: the single clock; all state updates on its rising edge.
REQ-003 Port reset, input, width 1: synchronous, active-low reset (0 = reset).
REQ-004 Port addr, input, width 32: byte address from the Memory stage ALU result.
REQ-005 Port wdata, input, width 32: store data; the relevant bits are right-aligned.
REQ-006 Port memWE, input, width 1: store request.
REQ-007 Port memRE, input, width 1: load request.
REQ-008 Port memcontrol, input, width 3: funct3 (0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU; stores use 0 SB, 1 SH, 2 SW).
REQ-009 Port rdata, output, width 32: extended load result to Writeback.
REQ-010 Port busy, output, width 1: stall to the core; the core holds all inputs stable while busy=1.
REQ-011 Port fault, output, width 1: sticky access-fault flag.
REQ-012 Port bus_req, output, width 1: memory bus request.
REQ-013 Port bus_we, output, width 1: bus write enable.
REQ-014 Port bus_addr, output, width 32: word-aligned bus address; bits [1:0] are always 0.
REQ-015 Port bus_wdata, output, width 32: lane-replicated store data.
REQ-016 Port bus_be, output, width 4: byte enables; bit i enables byte lane i.
REQ-017 Port bus_ack, input, width 1: single-cycle completion strobe from the bus.
REQ-018 Port bus_rdata, input, width 32: read word; valid in the cycle bus_ack=1.

Function
REQ-019 The FSM SHALL have three states: IDLE, REQ and DONE.
REQ-020 In IDLE, if memRE or memWE is high and the access is legal, the block SHALL assert busy combinationally in that same cycle, latch addr, wdata, memcontrol and the direction, and move to REQ.
REQ-021 In REQ, bus_req SHALL be 1 and bus_we, bus_addr, bus_wdata and bus_be SHALL be driven from the latched values; busy SHALL be 1.
REQ-022 A cycle in REQ with bus_ack=1 SHALL end the transaction: for a load, rdata is registered from bus_rdata; the FSM moves to DONE.
REQ-023 In DONE, busy SHALL be 0 and bus_req SHALL be 0; the FSM returns to IDLE after one cycle; all request inputs are ignored in DONE.
REQ-024 The minimum load latency SHALL be 3 cycles: request seen in IDLE, ack in REQ, rdata valid with busy=0 in DONE.
REQ-025 Store byte lanes:
- SB: bus_be = 1 << addr[1:0], bus_wdata = wdata[7:0] replicated to all 4 lanes.
- SH: bus_be = 0011 if addr[1]=0, else 1100; bus_wdata = wdata[15:0] replicated to both halves.
- SW: bus_be = 1111, bus_wdata = wdata.
REQ-026 Loads SHALL drive bus_be = 1111; the byte or half is selected by the latched addr[1:0] or addr[1].
REQ-027 LB and LH SHALL sign-extend the selected byte or half; LBU and LHU SHALL zero-extend; LW SHALL pass the full word.
REQ-028 rdata SHALL hold its value until the next completed load.
REQ-029 The following SHALL be illegal accesses:
- halfword with addr[0]=1;
- word with addr[1:0]!=0;
- memcontrol = 3, 6 or 7, or a store with memcontrol >= 3;
- memRE and memWE both high.
REQ-030 An illegal access seen in IDLE SHALL issue no bus request, set fault=1, set rdata=0 and move to DONE, so busy=0 in the following cycle.
REQ-031 The timeout counter SHALL clear on entering REQ and increment every REQ cycle without bus_ack.
REQ-032 When the timeout counter reaches TIMEOUT, the block SHALL drop bus_req on the next edge, set fault=1, set rdata=0 (loads only) and move to DONE.
REQ-033 bus_ack SHALL be ignored in IDLE and DONE.
REQ-034 fault SHALL stay 1 until reset and SHALL NOT block later accesses.

Reset
REQ-035 While reset=0 at a rising edge, the block SHALL set: state IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_be=0, rdata=0, fault=0, timeout counter 0; busy=0 after the edge.
REQ-036 Reset asserted mid-transaction SHALL abandon the access without completing it; a bus_ack arriving after reset SHALL be ignored.

Verification
REQ-037 LB at addr 0x103, bus_rdata=0x80FF_1234 acked the cycle after the request -> bus_addr=0x100, bus_be=1111; busy high for 2 cycles; rdata=0xFFFF_FF80 on the third cycle.
REQ-038 SH at addr 0x202, wdata=0x0000_ABCD -> bus_we=1, bus_be=1100, bus_wdata=0xABCD_ABCD, bus_addr=0x200.
REQ-039 LW at addr 0x101 -> bus_req never asserted; fault=1; rdata=0; busy returns to 0 after one cycle.
REQ-040 LHU at 0x2 with bus_ack held low, TIMEOUT=4 -> bus_req high for 4 cycles then 0; fault=1; rdata=0.
REQ-041 Reset pulsed low while in REQ, then bus_ack=1 the following cycle -> state IDLE, bus_req=0, rdata unchanged at 0.
REQ-042 Back-to-back SW then LBU on consecutive held requests -> exactly two bus transactions, each separated by a DONE cycle with busy=0.

Source files
------------

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_ctrl
//  Description : Memory-stage load/store controller. It turns one core
//                access into a single bus transaction with byte lanes and
//                extends load data. Illegal or timed-out accesses raise a
//                sticky fault flag.
//  Ports       : clk, reset (sync, active-low)
//                core side : addr, wdata, memWE, memRE, memcontrol -> rdata,
//                            busy, fault
//                bus side  : bus_req, bus_we, bus_addr, bus_wdata, bus_be
//                            <- bus_ack, bus_rdata
//  Revision    : 1.0  initial release
// ============================================================================
module data_mem_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        memWE,
    input  logic        memRE,
    input  logic [2:0]  memcontrol,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        fault,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam int            C_CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    // The abort fires on the edge that ends the TIMEOUT-th unacknowledged
    // REQ cycle, so the counter is compared against TIMEOUT-1.
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [C_CNT_W-1:0]  r_cnt;
    logic [2:0]          r_ctrl;
    logic [1:0]          r_off;
    logic                w_req;
    logic                w_legal;
    logic                w_tmo;
    logic [3:0]          w_be;
    logic [31:0]         w_wd;
    logic [7:0]          w_byte;
    logic [15:0]         w_half;
    logic [31:0]         w_load;

    assign w_req = memRE | memWE;
    assign w_tmo = (r_cnt == C_CNT_LAST);

    // Access legality check on the live core inputs.
    always_comb begin
        w_legal = 1'b1;
        if (memRE && memWE) begin
            w_legal = 1'b0;
        end
        case (memcontrol)
            3'd0, 3'd4: ;
            3'd1, 3'd5: if (addr[0])        w_legal = 1'b0;
            3'd2:       if (addr[1:0] != 2'b00) w_legal = 1'b0;
            default:    w_legal = 1'b0;
        endcase
        if (memWE && memcontrol[2]) begin
            w_legal = 1'b0;
        end
    end

    // Byte enables and lane-replicated store data.
    always_comb begin
        w_be = 4'b1111;
        w_wd = wdata;
        if (memWE) begin
            case (memcontrol[1:0])
                2'd0: begin
                    w_be = 4'b0001 << addr[1:0];
                    w_wd = {4{wdata[7:0]}};
                end
                2'd1: begin
                    w_be = addr[1] ? 4'b1100 : 4'b0011;
                    w_wd = {2{wdata[15:0]}};
                end
                default: ;
            endcase
        end
    end

    // Load lane select and extension, using the latched offset/funct3.
    always_comb begin
        w_byte = bus_rdata[{r_off, 3'b000} +: 8];
        w_half = r_off[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (r_ctrl)
            3'd0:    w_load = {{24{w_byte[7]}}, w_byte};
            3'd1:    w_load = {{16{w_half[15]}}, w_half};
            3'd4:    w_load = {24'd0, w_byte};
            3'd5:    w_load = {16'd0, w_half};
            default: w_load = bus_rdata;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and stall output.
    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    busy   = reset;
                    w_next = w_legal ? REQ : DONE;
                end
            end
            REQ: begin
                busy = reset;
                if (bus_ack || w_tmo) begin
                    w_next = DONE;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Datapath: bus outputs, latched access info, load result, fault.
    always_ff @(posedge clk) begin
        if (!reset) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'd0;
            bus_wdata <= 32'd0;
            bus_be    <= 4'd0;
            rdata     <= 32'd0;
            fault     <= 1'b0;
            r_cnt     <= '0;
            r_ctrl    <= 3'd0;
            r_off     <= 2'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        if (w_legal) begin
                            bus_req   <= 1'b1;
                            bus_we    <= memWE;
                            bus_addr  <= {addr[31:2], 2'b00};
                            bus_wdata <= w_wd;
                            bus_be    <= w_be;
                            r_ctrl    <= memcontrol;
                            r_off     <= addr[1:0];
                            r_cnt     <= '0;
                        end else begin
                            fault <= 1'b1;
                            rdata <= 32'd0;
                        end
                    end
                end
                REQ: begin
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        if (!bus_we) begin
                            rdata <= w_load;
                        end
                    end else if (w_tmo) begin
                        bus_req <= 1'b0;
                        fault   <= 1'b1;
                        if (!bus_we) begin
                            rdata <= 32'd0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem_ctrl
//  Description : Scoreboard bench for data_mem_ctrl (TIMEOUT = 4). Stimulus
//                pushes expected bus transactions and completion results;
//                a negedge monitor pops and compares them.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_data_mem_ctrl;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr, wdata, bus_rdata;
    logic        memWE, memRE, bus_ack;
    logic [2:0]  memcontrol;
    logic [31:0] rdata, bus_addr, bus_wdata;
    logic        busy, fault, bus_req, bus_we;
    logic [3:0]  bus_be;

    data_mem_ctrl #(.TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .addr(addr), .wdata(wdata),
        .memWE(memWE), .memRE(memRE), .memcontrol(memcontrol),
        .rdata(rdata), .busy(busy), .fault(fault),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_be(bus_be),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        int          len;
    } bus_t;

    typedef struct {
        logic [31:0] rd;
        logic        f;
        int          blen;
    } res_t;

    bus_t bq[$];
    res_t rq[$];

    int n_chk  = 0;
    int n_pass = 0;

    logic        m_fault;
    logic [31:0] m_rdata;
    logic        mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic logic is_legal(input logic re, input logic we,
                                      input logic [2:0] c, input logic [31:0] a);
        if (re && we) return 1'b0;
        if (c == 3 || c > 5) return 1'b0;
        if (we && c >= 3) return 1'b0;
        if ((c % 4) == 1 && (a % 2) != 0) return 1'b0;
        if (c == 2 && (a % 4) != 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] c, input logic [31:0] a,
                                             input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * (a % 4))) & 32'hFF;
        h = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
        case (c)
            3'd0:    return (b >= 128) ? b - 32'd256 : b;
            3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    // One access starting in an IDLE cycle; ends in the following IDLE cycle.
    // d = REQ cycles without ack before the ack (d >= TMO means never acked).
    task automatic do_txn(input logic re, input logic we, input logic [2:0] c,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int d, input logic [31:0] word, input logic hold);
        bus_t  b;
        res_t  r;
        int    nreq;
        logic  lg;
        lg = is_legal(re, we, c, a);
        nreq = (d < TMO) ? d + 1 : TMO;
        if (lg) begin
            b.we   = we;
            b.addr = a - (a % 4);
            b.len  = nreq;
            if (we && c == 0) begin
                b.be = 4'(1 << (a % 4));
                b.wd = (wd & 32'hFF) * 32'h0101_0101;
            end else if (we && c == 1) begin
                b.be = ((a / 2) % 2 == 1) ? 4'hC : 4'h3;
                b.wd = (wd & 32'hFFFF) * 32'h0001_0001;
            end else begin
                b.be = 4'hF;
                b.wd = wd;
            end
            bq.push_back(b);
            if (d >= TMO) m_fault = 1'b1;
            if (re) m_rdata = (d < TMO) ? exp_load(c, a, word) : 32'd0;
            r.blen = nreq + 1;
        end else begin
            m_fault = 1'b1;
            m_rdata = 32'd0;
            r.blen  = 1;
        end
        r.rd = m_rdata;
        r.f  = m_fault;
        rq.push_back(r);

        memRE = re; memWE = we; memcontrol = c; addr = a; wdata = wd;
        tick();
        if (lg) begin
            for (int i = 0; i < TMO; i++) begin
                bus_ack   = (i == d);
                bus_rdata = (i == d) ? word : $urandom;
                tick();
                if (i == d) break;
            end
        end
        // DONE cycle: a stray ack here must be ignored
        bus_ack   = 1'($urandom_range(0, 1));
        bus_rdata = $urandom;
        if (!hold) begin
            memRE = 1'b0;
            memWE = 1'b0;
        end
        tick();
        bus_ack = 1'b0;
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic prev_req = 1'b0, prev_busy = 1'b0;
    int   req_len = 0, busy_len = 0;
    bus_t cur_b;
    res_t cur_r;

    always @(negedge clk) begin
        if (mon_en) begin
            chk("bus_addr_low_bits", {30'd0, bus_addr[1:0]}, 32'd0);
            if (bus_req) begin
                if (!prev_req) begin
                    req_len = 0;
                    if (bq.size() == 0) begin
                        chk("bus_unexpected_req", 32'd1, 32'd0);
                        cur_b.len = -1;
                    end else begin
                        cur_b = bq.pop_front();
                        chk("bus_we", {31'd0, bus_we}, {31'd0, cur_b.we});
                        chk("bus_addr", bus_addr, cur_b.addr);
                        chk("bus_be", {28'd0, bus_be}, {28'd0, cur_b.be});
                        if (cur_b.we) chk("bus_wdata", bus_wdata, cur_b.wd);
                    end
                end
                req_len++;
            end else if (prev_req) begin
                chk("bus_req_cycles", req_len, cur_b.len);
            end
            if (busy) begin
                busy_len++;
            end else if (prev_busy) begin
                if (rq.size() == 0) begin
                    chk("unexpected_completion", 32'd1, 32'd0);
                end else begin
                    cur_r = rq.pop_front();
                    chk("rdata", rdata, cur_r.rd);
                    chk("fault", {31'd0, fault}, {31'd0, cur_r.f});
                    chk("busy_cycles", busy_len, cur_r.blen);
                    chk("done_bus_req", {31'd0, bus_req}, 32'd0);
                end
                busy_len = 0;
            end
        end
        prev_req  = bus_req;
        prev_busy = busy;
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic        re, we, hold;
        logic [2:0]  c;
        logic [31:0] a;
        reset = 1'b0; memRE = 1'b0; memWE = 1'b0; memcontrol = 3'd0;
        addr = 32'd0; wdata = 32'd0; bus_ack = 1'b0; bus_rdata = 32'd0;
        m_fault = 1'b0; m_rdata = 32'd0;
        tick(); tick();
        reset = 1'b1;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        chk("rst_bus_be", {28'd0, bus_be}, 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);

        // Reset while in REQ, then an ack after reset
        memRE = 1'b1; memcontrol = 3'd2; addr = 32'h40;
        tick();                       // REQ cycle 0
        tick();                       // REQ cycle 1
        reset = 1'b0;
        tick();                       // reset applied
        reset = 1'b1; memRE = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        #1;
        chk("rstmid_bus_req", {31'd0, bus_req}, 32'd0);
        chk("rstmid_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("rstmid_rdata", rdata, 32'd0);
        chk("rstmid_bus_req2", {31'd0, bus_req}, 32'd0);
        chk("rstmid_fault", {31'd0, fault}, 32'd0);
        bus_ack = 1'b0;
        tick();

        mon_en = 1'b1;
        // LB at 0x103, ack in the first REQ cycle
        do_txn(1'b1, 1'b0, 3'd0, 32'h103, 32'd0, 0, 32'h80FF_1234, 1'b0);
        // SH at 0x202
        do_txn(1'b0, 1'b1, 3'd1, 32'h202, 32'h0000_ABCD, 1, 32'd0, 1'b0);
        // LW misaligned -> fault, no bus request
        do_txn(1'b1, 1'b0, 3'd2, 32'h101, 32'd0, 0, 32'd0, 1'b0);
        // LHU at 0x2 never acked -> timeout
        do_txn(1'b1, 1'b0, 3'd5, 32'h2, 32'd0, 99, 32'h1234_5678, 1'b0);
        // Back-to-back held SW then LBU
        do_txn(1'b0, 1'b1, 3'd2, 32'h300, 32'hCAFE_F00D, 0, 32'd0, 1'b1);
        do_txn(1'b1, 1'b0, 3'd4, 32'h301, 32'd0, 0, 32'h0000_9A00, 1'b0);

        // Randomized accesses
        for (int n = 0; n < 60; n++) begin
            c  = 3'($urandom_range(0, 7));
            we = 1'($urandom_range(0, 1));
            re = ~we;
            if ($urandom_range(0, 15) == 0) begin
                re = 1'b1;
                we = 1'b1;
            end
            a = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (c == 3'd2) a[1:0] = 2'b00;
                if (c == 3'd1 || c == 3'd5) a[0] = 1'b0;
            end
            hold = 1'($urandom_range(0, 1));
            do_txn(re, we, c, a, $urandom, $urandom_range(0, 5), $urandom, hold);
            if (!hold && $urandom_range(0, 1) == 1) begin
                bus_ack = 1'b1;       // ack in IDLE without a request
                tick();
                bus_ack = 1'b0;
            end
        end
        memRE = 1'b0; memWE = 1'b0;
        tick(); tick();
        chk("bus_queue_drained", bq.size(), 32'd0);
        chk("result_queue_drained", rq.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
